// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-handling controller.
// Contents: fill controller state enum, block offset and word index widths.
package cache_pkg;

  typedef enum logic [1:0] {
    CF_IDLE,
    CF_FILL,
    CF_COMMIT
  } cf_state_e;

  // Byte offset bits within a block, and word index bits within a block.
  localparam int unsigned BLOCK_OFFSET_W = 4;
  localparam int unsigned WORD_IDX_W     = 3;

endpackage

// File: rtl/fill_counter.sv
// Saturating 4-bit up-counter with synchronous clear.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one, holding at MAX
//   cnt      : current count
module fill_counter #(
  parameter int unsigned MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= 4'd0;
    end else if (inc && (cnt_q < 4'(MAX))) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller for the two-way, 64-set, 8-word-block cache array.
// On a miss it stalls the CPU, streams one block from pipelined memory into the
// array, marks the tag valid on the last word, then replays the original access.
// Optional feature macro: CACHE_FILL_STATS_EN adds the saturating miss_count port.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/addr/write : CPU access
//   cache_miss        : array miss flag for cache_addr
//   mem_valid         : memory returns one word
//   mem_rd, mem_addr  : memory read request
//   cache_addr, cache_wren, cache_rewrite, data_sel : array controls
//   stall             : hold CPU memory stage
//   fill_done         : one-cycle pulse in the commit cycle
//   miss_count        : miss statistics (macro only)
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              cache_miss,
  input  logic              mem_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_wren,
  output logic              cache_rewrite,
  output logic              data_sel,
  output logic              stall,
`ifdef CACHE_FILL_STATS_EN
  output logic [15:0]       miss_count,
`endif
  output logic              fill_done
);

  // Counters are 4 bits wide and the word index occupies the block offset above
  // the byte-in-word bit, so only these shapes are supported.
  if (((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
      (WORDS_PER_BLOCK > (1 << WORD_IDX_W)) || (MEM_LATENCY == 0)) begin : g_bad_cfg
    $error("cache_fill_ctrl: unsupported parameter set");
  end

  localparam int unsigned ByteShift = BLOCK_OFFSET_W - WORD_IDX_W;
  localparam logic [ADDR_W-1:0] BlockMask = ~ADDR_W'((1 << BLOCK_OFFSET_W) - 1);

  cf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] saved_addr_q;
  logic              saved_write_q;
  logic [3:0]        issue_cnt;
  logic [3:0]        recv_cnt;

  logic              miss_entry;
  logic              fill_valid;
  logic              last_word;
  logic [ADDR_W-1:0] issue_off;
  logic [ADDR_W-1:0] recv_off;

  assign miss_entry = (state_q == CF_IDLE) && req_valid && cache_miss;
  // Returns outside FILL are stale (e.g. after a reset) and are dropped.
  assign fill_valid = (state_q == CF_FILL) && mem_valid;
  assign last_word  = fill_valid && (recv_cnt == 4'(WORDS_PER_BLOCK - 1));
  assign issue_off  = ADDR_W'(issue_cnt) << ByteShift;
  assign recv_off   = ADDR_W'(recv_cnt) << ByteShift;

  fill_counter #(
    .MAX(WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk(clk),
    .rst(rst),
    .clr(miss_entry),
    .inc(mem_rd),
    .cnt(issue_cnt)
  );

  fill_counter #(
    .MAX(WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk(clk),
    .rst(rst),
    .clr(miss_entry),
    .inc(fill_valid),
    .cnt(recv_cnt)
  );

  // State register and miss-entry captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CF_IDLE;
      base_q        <= '0;
      saved_addr_q  <= '0;
      saved_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_entry) begin
        base_q        <= req_addr & BlockMask;
        saved_addr_q  <= req_addr;
        saved_write_q <= req_write;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CF_IDLE:   if (miss_entry) state_d = CF_FILL;
      CF_FILL:   if (last_word) state_d = CF_COMMIT;
      CF_COMMIT: state_d = CF_IDLE;
      default:   state_d = CF_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    mem_rd        = 1'b0;
    mem_addr      = base_q + issue_off;
    cache_addr    = req_addr;
    cache_wren    = 1'b0;
    cache_rewrite = 1'b0;
    data_sel      = 1'b0;
    stall         = 1'b0;
    fill_done     = 1'b0;
    unique case (state_q)
      CF_IDLE: begin
        stall      = req_valid && cache_miss;
        cache_wren = req_valid && req_write && !cache_miss;
      end
      CF_FILL: begin
        stall      = 1'b1;
        mem_rd     = issue_cnt < 4'(WORDS_PER_BLOCK);
        cache_addr = base_q;
        if (mem_valid) begin
          // Bit 0 set marks this as a live array write request.
          cache_addr    = base_q | recv_off | ADDR_W'(1);
          cache_wren    = 1'b1;
          data_sel      = 1'b1;
          cache_rewrite = last_word;
        end
      end
      CF_COMMIT: begin
        stall      = 1'b1;
        fill_done  = 1'b1;
        cache_addr = saved_addr_q;
        cache_wren = saved_write_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] miss_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count_q <= 16'd0;
    end else if (miss_entry && (miss_count_q != 16'hFFFF)) begin
      miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: hit, read miss, store miss, bubbly memory,
// reset mid-fill and (with CACHE_FILL_STATS_EN) the miss counter.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_write;
  logic        cache_miss;
  logic        mem_valid;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] cache_addr;
  logic        cache_wren;
  logic        cache_rewrite;
  logic        data_sel;
  logic        stall;
  logic        fill_done;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl #(
    .WORDS_PER_BLOCK(8),
    .MEM_LATENCY(4),
    .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_write(req_write),
    .cache_miss(cache_miss),
    .mem_valid(mem_valid),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .cache_addr(cache_addr),
    .cache_wren(cache_wren),
    .cache_rewrite(cache_rewrite),
    .data_sel(data_sel),
    .stall(stall),
`ifdef CACHE_FILL_STATS_EN
    .miss_count(miss_count),
`endif
    .fill_done(fill_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss at addr in cycle 0; memory returns word k in cycle vstart + k*vstep.
  task automatic run_fill(input logic [15:0] addr, input logic wr, input int vstart,
                          input int vstep);
    logic [15:0] base;
    int          rcv;
    int          writes;
    int          last;
    int          commit;
    logic        mv;
    base   = addr & 16'hFFF0;
    rcv    = 0;
    writes = 0;
    last   = vstart + 7 * vstep;
    commit = last + 1;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_write  = wr;
    cache_miss = 1'b1;
    mem_valid  = 1'b0;
    #2;
    check("miss_stall", stall, 1);
    check("miss_no_rd", mem_rd, 0);
    check("miss_no_wren", cache_wren, 0);
    tick();
    cache_miss = 1'b0;
    for (int c = 1; c <= commit; c++) begin
      mv = (c >= vstart) && (c <= last) && (((c - vstart) % vstep) == 0);
      mem_valid = mv;
      #2;
      check("fill_stall", stall, 1);
      check("fill_mem_rd", mem_rd, (c <= 8) ? 1 : 0);
      if (c <= 8) check("fill_mem_addr", mem_addr, base + 16'(2 * (c - 1)));
      if (c < commit) begin
        check("fill_wren", cache_wren, mv);
        check("fill_cache_addr", cache_addr, mv ? (base | 16'(rcv << 1) | 16'h1) : base);
        if (mv) check("fill_data_sel", data_sel, 1);
        check("fill_rewrite", cache_rewrite, (mv && rcv == 7) ? 1 : 0);
        check("fill_done_low", fill_done, 0);
        if (cache_wren) writes++;
      end else begin
        check("commit_fill_done", fill_done, 1);
        check("commit_wren", cache_wren, wr);
        check("commit_addr", cache_addr, addr);
        check("commit_data_sel", data_sel, 0);
        check("commit_rewrite", cache_rewrite, 0);
      end
      if (mv) rcv++;
      tick();
    end
    check("fill_write_count", writes, 8);
    mem_valid = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    #2;
    check("resume_stall", stall, 0);
    check("resume_fill_done", fill_done, 0);
    check("resume_mem_rd", mem_rd, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 16'h0;
    req_write  = 1'b0;
    cache_miss = 1'b0;
    mem_valid  = 1'b0;
    #12;
    check("rst_stall", stall, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_wren", cache_wren, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_rewrite", cache_rewrite, 0);
`ifdef CACHE_FILL_STATS_EN
    check("rst_miss_count", miss_count, 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Read hit, then store hit.
    req_valid = 1'b1;
    req_addr  = 16'h0120;
    #2;
    check("hit_stall", stall, 0);
    check("hit_mem_rd", mem_rd, 0);
    check("hit_wren", cache_wren, 0);
    check("hit_cache_addr", cache_addr, 16'h0120);
    tick();
    req_write = 1'b1;
    #2;
    check("store_hit_wren", cache_wren, 1);
    check("store_hit_data_sel", data_sel, 0);
    check("store_hit_stall", stall, 0);
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    #2;
    check("after_hit_mem_rd", mem_rd, 0);
    tick();

    // Read miss, L = 4: returns in cycles 5..12.
    run_fill(16'h0456, 1'b0, 5, 1);
    // Store miss, L = 4.
    run_fill(16'h8002, 1'b1, 5, 1);
    // Bubbly memory: returns on odd cycles only.
    run_fill(16'h0100, 1'b0, 1, 2);

    // Reset in cycle 6 of a fill.
    req_valid  = 1'b1;
    req_addr   = 16'h0200;
    cache_miss = 1'b1;
    tick();
    cache_miss = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      mem_valid = (c == 5);
      tick();
    end
    mem_valid = 1'b0;
    #2;
    check("pre_rst_mem_rd", mem_rd, 1);
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_valid = 1'b1;
    #1;
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_stall", stall, 0);
    check("midrst_wren", cache_wren, 0);
    check("midrst_rewrite", cache_rewrite, 0);
    check("midrst_data_sel", data_sel, 0);
    check("midrst_fill_done", fill_done, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_valid = 1'b1;
      #2;
      check("stale_wren", cache_wren, 0);
      check("stale_stall", stall, 0);
      check("stale_mem_rd", mem_rd, 0);
      tick();
    end
    mem_valid = 1'b0;

`ifdef CACHE_FILL_STATS_EN
    check("stats_after_rst", miss_count, 0);
    run_fill(16'h1000, 1'b0, 1, 1);
    run_fill(16'h2004, 1'b1, 1, 1);
    req_valid = 1'b1;
    req_addr  = 16'h1000;
    tick();
    req_addr = 16'h2004;
    tick();
    req_valid = 1'b0;
    run_fill(16'h300A, 1'b0, 2, 1);
    #2;
    check("stats_miss_count", miss_count, 3);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
